// File: rtl/leds_racer_pkg.sv
// Shared definitions for the racer LED strip: player ids, player colours (GRB)
// and the frame sequencer state encoding.
package leds_racer_pkg;

   localparam logic [1:0] PLAYER_GREEN  = 2'd0;
   localparam logic [1:0] PLAYER_RED    = 2'd1;
   localparam logic [1:0] PLAYER_BLUE   = 2'd2;
   localparam logic [1:0] PLAYER_YELLOW = 2'd3;

   localparam logic [23:0] COLOUR_GREEN  = 24'hFF0000;
   localparam logic [23:0] COLOUR_RED    = 24'h00FF00;
   localparam logic [23:0] COLOUR_BLUE   = 24'h0000FF;
   localparam logic [23:0] COLOUR_YELLOW = 24'hFFFF00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   function automatic logic [23:0] player_colour(input logic [1:0] id);
      logic [23:0] c;
      case (id)
         PLAYER_GREEN:  c = COLOUR_GREEN;
         PLAYER_RED:    c = COLOUR_RED;
         PLAYER_BLUE:   c = COLOUR_BLUE;
         PLAYER_YELLOW: c = COLOUR_YELLOW;
         default:       c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/leds_frame_scheduler_if.sv
// Pixel stream towards the WS2812 bit encoder. A pixel transfers on a cycle with
// pixel_valid & pixel_ready; once raised, pixel_valid and pixel_grb stay stable until that transfer.
interface leds_frame_scheduler_if;

   logic        pixel_valid;
   logic [23:0] pixel_grb;
   logic        pixel_ready;

   modport master (output pixel_valid, output pixel_grb, input pixel_ready);
   modport slave  (input pixel_valid, input pixel_grb, output pixel_ready);

endinterface

// File: rtl/leds_pixel_arbiter.sv
// Combinational colour pick for one LED: among enabled players sitting on idx,
// the first one found scanning ids prio, prio+1, .. (mod 4) wins.
module leds_pixel_arbiter
   import leds_racer_pkg::*;
#(
   parameter int POS_W   = 7,
   parameter int MAX_POS = 109
) (
   input  logic [POS_W-1:0]      idx,
   input  logic [3:0][POS_W-1:0] pos,
   input  logic [3:0]            en,
   input  logic [1:0]            prio,
   output logic [23:0]           grb
);

   logic [3:0] cand;

   always_comb begin
      cand = '0;
      for (int p = 0; p < 4; p++) begin
         cand[p] = en[p] && (pos[p] == idx) && (pos[p] <= POS_W'(MAX_POS));
      end
   end

   // Rotating start point makes overlapping players alternate colour per frame.
   always_comb begin
      logic       found;
      logic [1:0] id;
      grb   = 24'h000000;
      found = 1'b0;
      id    = prio;
      for (int k = 0; k < 4; k++) begin
         id = prio + 2'(k);
         if (!found && cand[id]) begin
            grb   = player_colour(id);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/leds_frame_scheduler.sv
// Frame sequencer for the racer LED strip: snapshots player positions, streams
// one GRB pixel per LED to the encoder, then holds the strip latch gap.
module leds_frame_scheduler
   import leds_racer_pkg::*;
#(
   parameter int MAX_POS       = 109,
   parameter int LATCH_CLK_CNT = 2500,
   parameter int POS_W         = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                update_frame,
   input  logic [3:0]          player_en,
   input  logic [POS_W-1:0]    pos_green,
   input  logic [POS_W-1:0]    pos_red,
   input  logic [POS_W-1:0]    pos_blue,
   input  logic [POS_W-1:0]    pos_yellow,
   leds_frame_scheduler_if.master pix,
   output logic                busy,
   output logic                frame_done,
   output logic                tp_update_frame,
   output state_t              dbg_state
);

   localparam int CNT_W = (LATCH_CLK_CNT < 2) ? 1 : $clog2(LATCH_CLK_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CLK_CNT - 1);
   localparam logic [POS_W-1:0] IDX_LAST = POS_W'(MAX_POS);

   state_t               state_q, state_d;
   logic [POS_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pending_q, pending_d;
   logic [1:0]           prio_q, prio_d;
   logic [3:0][POS_W-1:0] snap_pos_q, snap_pos_d;
   logic [3:0]           snap_en_q, snap_en_d;
   logic                 pixel_valid_q, pixel_valid_d;
   logic [23:0]          pixel_grb_q, pixel_grb_d;
   logic                 tp_q, tp_d;

   logic        handshake, latch_end, restart, start;
   logic [23:0] arb_grb;

   assign handshake = (state_q == ST_SEND) && pixel_valid_q && pix.pixel_ready;
   assign latch_end = (state_q == ST_LATCH) && (cnt_q == CNT_LAST);
   // A request in the frame_done cycle is treated exactly like a pending one.
   assign restart   = latch_end && (pending_q || update_frame);
   assign start     = ((state_q == ST_IDLE) && update_frame) || restart;

   leds_pixel_arbiter #(.POS_W(POS_W), .MAX_POS(MAX_POS)) u_arbiter (
      .idx  (idx_q),
      .pos  (snap_pos_q),
      .en   (snap_en_q),
      .prio (prio_q),
      .grb  (arb_grb)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         pending_q     <= 1'b0;
         prio_q        <= 2'd0;
         snap_pos_q    <= '0;
         snap_en_q     <= '0;
         pixel_valid_q <= 1'b0;
         pixel_grb_q   <= '0;
         tp_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         prio_q        <= prio_d;
         snap_pos_q    <= snap_pos_d;
         snap_en_q     <= snap_en_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_grb_q   <= pixel_grb_d;
         tp_q          <= tp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (update_frame) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_SEND;
         ST_SEND:  if (handshake) state_d = (idx_q == IDX_LAST) ? ST_LATCH : ST_FETCH;
         ST_LATCH: if (latch_end) state_d = restart ? ST_FETCH : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      pending_d     = pending_q;
      prio_d        = prio_q;
      snap_pos_d    = snap_pos_q;
      snap_en_d     = snap_en_q;
      pixel_valid_d = pixel_valid_q;
      pixel_grb_d   = pixel_grb_q;
      tp_d          = start;

      if ((state_q != ST_IDLE) && update_frame) pending_d = 1'b1;

      case (state_q)
         ST_FETCH: begin
            pixel_grb_d   = arb_grb;
            pixel_valid_d = 1'b1;
         end
         ST_SEND: begin
            if (handshake) begin
               pixel_valid_d = 1'b0;
               if (idx_q == IDX_LAST) cnt_d = '0;
               else                   idx_d = idx_q + 1'b1;
            end
         end
         ST_LATCH: begin
            pixel_valid_d = 1'b0;
            cnt_d         = cnt_q + 1'b1;
            if (latch_end) begin
               cnt_d  = '0;
               prio_d = prio_q + 2'd1;
            end
         end
         default: ;
      endcase

      // Frame start takes a tear-free snapshot and consumes any pending request.
      if (start) begin
         snap_pos_d = {pos_yellow, pos_blue, pos_red, pos_green};
         snap_en_d  = player_en;
         idx_d      = '0;
         pending_d  = 1'b0;
      end
   end

   always_comb begin
      busy            = (state_q != ST_IDLE);
      frame_done      = latch_end;
      tp_update_frame = tp_q;
      dbg_state       = state_q;
      pix.pixel_valid = pixel_valid_q;
      pix.pixel_grb   = pixel_grb_q;
   end

endmodule
